alu_scheduler: RTL and testbench

//   Shares one combinational N-bit ALU between two requesters. Each requester presents A, B and a 2-bit op.
//   A round-robin arbiter picks one request; the block drives the ALU, registers the result and the
//   {V,C,Neg,Z} flags, and returns a one-cycle ack.

---
 rtl/alu_scheduler.sv | 85 ++++++++
 tb/tb_alu_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// Round-robin scheduler that shares one external combinational ALU between two requesters.
// Each transaction runs IDLE -> EXEC -> DONE, returning a registered result/flags and a one-cycle ack.
module alu_scheduler #(
  parameter int N    = 8,
  parameter int CNTW = 8
) (
  input  logic            CLK50M,
  input  logic            RST,
  input  logic [1:0]      req,
  input  logic [N-1:0]    a0,
  input  logic [N-1:0]    b0,
  input  logic [1:0]      op0,
  input  logic [N-1:0]    a1,
  input  logic [N-1:0]    b1,
  input  logic [1:0]      op1,
  output logic [1:0]      ack,
  output logic [N-1:0]    result,
  output logic [3:0]      flags,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [1:0]      alu_ctrl,
  input  logic [N-1:0]    alu_res,
  input  logic [3:0]      alu_flags,
  output logic            busy,
  output logic            owner,
  output logic [CNTW-1:0] ops_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state;
  logic   last;
  logic   grant;

  // On contention the requester that was not served last wins.
  always_comb begin
    grant = (req == 2'b11) ? ~last : req[1];
  end

  always_ff @(posedge CLK50M) begin
    if (RST) begin
      state    <= IDLE;
      ack      <= 2'b00;
      result   <= '0;
      flags    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= 2'b00;
      busy     <= 1'b0;
      owner    <= 1'b0;
      ops_cnt  <= '0;
      last     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner    <= grant;
            busy     <= 1'b1;
            alu_a    <= grant ? a1 : a0;
            alu_b    <= grant ? b1 : b0;
            alu_ctrl <= grant ? op1 : op0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          result <= alu_res;
          flags  <= alu_flags;
          ack    <= owner ? 2'b10 : 2'b01;
          state  <= DONE;
        end
        DONE: begin
          ack     <= 2'b00;
          last    <= owner;
          ops_cnt <= ops_cnt + CNTW'(1);
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: models the external ALU, drives transactions and scores acks.
// Expected results are queued at stimulus time and popped whenever an ack appears.
module tb_alu_scheduler;

  logic       CLK50M = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0] op0 = '0, op1 = '0;
  logic [1:0] ack;
  logic [7:0] result, alu_a, alu_b, alu_res;
  logic [3:0] flags, alu_flags;
  logic [1:0] alu_ctrl;
  logic       busy, owner;
  logic [7:0] ops_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         owner;
    logic [7:0] res;
    logic [3:0] flg;
    int         due;
  } sb_entry_t;
  sb_entry_t sb[$];

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;
  vec_t vecs[8];

  alu_scheduler #(.N(8), .CNTW(8)) dut (
    .CLK50M(CLK50M), .RST(RST), .req(req),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .ack(ack), .result(result), .flags(flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_flags(alu_flags),
    .busy(busy), .owner(owner), .ops_cnt(ops_cnt)
  );

  always #10 CLK50M = ~CLK50M;
  always @(posedge CLK50M) cyc <= cyc + 1;

  // Reference ALU: returns {result, V, C, Neg, Z}.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [8:0] s;
    logic v, c;
    s = '0; v = 1'b0; c = 1'b0;
    case (op)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; c = s[8]; v = (a[7] == b[7]) && (s[7] != a[7]); end
      2'b01: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; c = s[8]; v = (a[7] != b[7]) && (s[7] != a[7]); end
      2'b10: s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    return {s[7:0], v, c, s[7], (s[7:0] == 8'h00)};
  endfunction

  always_comb begin
    {alu_res, alu_flags} = alu_ref(alu_a, alu_b, alu_ctrl);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest queued expectation.
  always @(negedge CLK50M) begin
    if (ack !== 2'b00) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_ack", {30'd0, ack}, 32'd0);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        checkOutput("ack_onehot", {30'd0, ack}, 32'd1 << e.owner);
        checkOutput("result", {24'd0, result}, {24'd0, e.res});
        checkOutput("flags", {28'd0, flags}, {28'd0, e.flg});
        if (e.due >= 0) checkOutput("ack_cycle", cyc, e.due);
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK50M);
    RST = 1'b1;
    req = 2'b00;
    repeat (2) @(negedge CLK50M);
    RST = 1'b0;
    checkOutput("sb_drained_at_reset", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_ack(input int id);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge CLK50M);
      if (ack[id]) seen = 1'b1;
    end
    if (!seen) checkOutput("ack_timeout", 0, 1);
    req[id] = 1'b0;
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] op, input logic [7:0] res, input logic [3:0] flg);
    @(negedge CLK50M);
    if (id == 0) begin a0 = a; b0 = b; op0 = op; end
    else begin a1 = a; b1 = b; op1 = op; end
    req[id] = 1'b1;
    sb.push_back(sb_entry_t'{id, res, flg, cyc + 2});
    @(negedge CLK50M);
    checkOutput("busy_exec", {31'd0, busy}, 32'd1);
    checkOutput("owner_exec", {31'd0, owner}, id);
    checkOutput("alu_ops", {14'd0, alu_a, alu_b, alu_ctrl}, {14'd0, a, b, op});
    wait_ack(id);
  endtask

  initial begin
    logic [11:0] r;
    logic [7:0] ra, rb;

    vecs[0] = '{0, 8'h05, 8'h03, 2'b00, 8'h08, 4'b0000};
    vecs[1] = '{1, 8'h7F, 8'h01, 2'b00, 8'h80, 4'b1010};
    vecs[2] = '{0, 8'h10, 8'h10, 2'b01, 8'h00, 4'b0101};
    vecs[3] = '{1, 8'hFF, 8'h01, 2'b00, 8'h00, 4'b0101};
    vecs[4] = '{0, 8'h00, 8'h01, 2'b01, 8'hFF, 4'b0010};
    vecs[5] = '{1, 8'h80, 8'h01, 2'b01, 8'h7F, 4'b1100};
    vecs[6] = '{0, 8'hF0, 8'h0F, 2'b10, 8'h00, 4'b0001};
    vecs[7] = '{1, 8'h0F, 8'hF0, 2'b11, 8'hFF, 4'b0010};

    do_reset();
    @(negedge CLK50M);
    checkOutput("reset_outputs", {ack, result, flags, alu_a, alu_b, alu_ctrl},
                {2'b00, 8'h00, 4'h0, 8'h00, 8'h00, 2'b00});
    checkOutput("reset_status", {22'd0, busy, owner, ops_cnt}, 32'd0);

    // Table of single-requester transactions.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg);
      @(negedge CLK50M);
      checkOutput("ops_cnt_table", {24'd0, ops_cnt}, i + 1);
      checkOutput("busy_idle", {31'd0, busy}, 32'd0);
    end

    // Contention right after reset: requester 0 first, then 1.
    do_reset();
    @(negedge CLK50M);
    a0 = 8'h7F; b0 = 8'h01; op0 = 2'b00;
    a1 = 8'h10; b1 = 8'h10; op1 = 2'b01;
    req = 2'b11;
    sb.push_back(sb_entry_t'{0, 8'h80, 4'b1010, cyc + 2});
    sb.push_back(sb_entry_t'{1, 8'h00, 4'b0101, cyc + 5});
    wait_ack(0);
    wait_ack(1);
    repeat (2) @(negedge CLK50M);
    checkOutput("sb_drained_contention", sb.size(), 0);

    // Sustained contention: owners alternate, one ack every three cycles.
    do_reset();
    @(negedge CLK50M);
    a0 = 8'h21; b0 = 8'h12; op0 = 2'b00;
    a1 = 8'h50; b1 = 8'h05; op1 = 2'b01;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      sb.push_back(sb_entry_t'{k % 2, (k % 2) ? 8'h4B : 8'h33, (k % 2) ? 4'b0100 : 4'b0000, cyc + 2 + 3 * k});
    end
    repeat (11) @(negedge CLK50M);
    req = 2'b00;
    repeat (3) @(negedge CLK50M);
    checkOutput("sb_drained_alternate", sb.size(), 0);
    checkOutput("ops_cnt_alternate", {24'd0, ops_cnt}, 32'd4);

    // Reset during EXEC drops the transaction.
    @(negedge CLK50M);
    a0 = 8'hAA; b0 = 8'h55; op0 = 2'b11;
    req = 2'b01;
    @(negedge CLK50M);
    checkOutput("busy_before_abort", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    req = 2'b00;
    @(negedge CLK50M);
    RST = 1'b0;
    checkOutput("abort_outputs", {ack, result, flags, alu_a, alu_b, alu_ctrl},
                {2'b00, 8'h00, 4'h0, 8'h00, 8'h00, 2'b00});
    checkOutput("abort_status", {22'd0, busy, owner, ops_cnt}, 32'd0);
    repeat (6) @(negedge CLK50M);

    // Request dropped and operands changed after grant.
    @(negedge CLK50M);
    a0 = 8'h33; b0 = 8'h11; op0 = 2'b01;
    req = 2'b01;
    sb.push_back(sb_entry_t'{0, 8'h22, 4'b0100, cyc + 2});
    @(negedge CLK50M);
    req = 2'b00;
    a0 = 8'hFF; b0 = 8'hFF; op0 = 2'b11;
    wait_ack(0);
    repeat (2) @(negedge CLK50M);
    checkOutput("sb_drained_drop", sb.size(), 0);

    // Counter wrap over 256 operations.
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      r = alu_ref(ra, rb, 2'b00);
      applyStimulus(i % 2, ra, rb, 2'b00, r[11:4], r[3:0]);
      if (i == 255) begin
        @(negedge CLK50M);
        checkOutput("ops_cnt_255", {24'd0, ops_cnt}, 32'hFF);
      end
    end
    @(negedge CLK50M);
    checkOutput("ops_cnt_wrap", {24'd0, ops_cnt}, 32'h00);
    checkOutput("sb_drained_final", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
